// File: rtl/kernel_stream_pack_pkg.sv
// Shared config addresses and state encoding for the kernel stream packer.
// CFG_KER_STR is also decoded by the config decoder and the kernel buffer.
package kernel_stream_pack_pkg;

  localparam logic [4:0] CFG_KER_WR  = 5'd1;
  localparam logic [4:0] CFG_KER_STR = 5'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/kernel_stream_pack.sv
// Packs RATIO narrow host kernel beats into one wide str_ker word.
// A config write arms N beats; a trailing partial word is zero padded.
module kernel_stream_pack
  import kernel_stream_pack_pkg::*;
#(
  parameter int CFG_DWIDTH    = 32,
  parameter int CFG_AWIDTH    = 5,
  parameter int STR_KER_WIDTH = 64,
  parameter int GROUP_NB      = 4,
  parameter int KER_WIDTH     = 16,
  parameter int DEPTH_NB      = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [CFG_DWIDTH-1:0]                       cfg_data,
  input  logic [CFG_AWIDTH-1:0]                       cfg_addr,
  input  logic                                        cfg_valid,
  input  logic [STR_KER_WIDTH-1:0]                    up_data,
  input  logic                                        up_val,
  output logic                                        up_rdy,
  output logic [GROUP_NB*KER_WIDTH*DEPTH_NB-1:0]      str_ker,
  output logic                                        str_ker_val,
  input  logic                                        str_ker_rdy,
  output logic                                        busy
);

  localparam int OUT_WIDTH = GROUP_NB * KER_WIDTH * DEPTH_NB;
  localparam int RATIO     = OUT_WIDTH / STR_KER_WIDTH;
  localparam int SLOT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if (RATIO < 1 || (OUT_WIDTH % STR_KER_WIDTH) != 0) begin : g_ratio_check
    $error("kernel_stream_pack: OUT_WIDTH must be an integer multiple (>=1) of STR_KER_WIDTH");
  end

  state_t                   state_reg, state_next;
  logic [CFG_DWIDTH-1:0]    cnt_reg;
  logic [SLOT_W-1:0]        slot_reg;
  logic [STR_KER_WIDTH-1:0] asm_reg [RATIO];
  logic                     asm_full_reg;
  logic [OUT_WIDTH-1:0]     out_reg;
  logic                     out_val_reg;

  logic                     cfg_hit;
  logic                     accept;
  logic                     last_beat;
  logic                     complete;
  logic                     out_free;
  logic                     load_out;
  logic [OUT_WIDTH-1:0]     asm_word;

  assign cfg_hit   = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_KER_STR)) &&
                     (state_reg == ST_IDLE) && (cfg_data != '0);
  assign accept    = up_val && up_rdy;
  assign last_beat = accept && (cnt_reg == CFG_DWIDTH'(1));
  assign complete  = accept && ((slot_reg == SLOT_W'(RATIO - 1)) || (cnt_reg == CFG_DWIDTH'(1)));
  assign out_free  = !out_val_reg || str_ker_rdy;
  // A completing beat bypasses straight into the output register when it
  // is free, so a word costs no extra cycle and the stream has no bubble.
  assign load_out  = (asm_full_reg || complete) && out_free;

  // Slots past the last beat of a short transfer are already zero because
  // the assembly register is cleared every time it is handed off.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_asm_word
    assign asm_word[gi*STR_KER_WIDTH +: STR_KER_WIDTH] =
      (accept && slot_reg == SLOT_W'(gi)) ? up_data : asm_reg[gi];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (cfg_hit) state_next = ST_ACTIVE;
      ST_ACTIVE: if (last_beat) state_next = ST_DRAIN;
      ST_DRAIN:  if (!asm_full_reg && !out_val_reg) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      slot_reg     <= '0;
      asm_full_reg <= 1'b0;
      out_reg      <= '0;
      out_val_reg  <= 1'b0;
      for (int i = 0; i < RATIO; i++) asm_reg[i] <= '0;
    end else begin
      state_reg <= state_next;

      if (cfg_hit)     cnt_reg <= cfg_data;
      else if (accept) cnt_reg <= cnt_reg - CFG_DWIDTH'(1);

      if (accept) slot_reg <= complete ? '0 : slot_reg + SLOT_W'(1);

      for (int i = 0; i < RATIO; i++) begin
        if (load_out) asm_reg[i] <= '0;
        else if (accept && slot_reg == SLOT_W'(i)) asm_reg[i] <= up_data;
      end

      if (load_out)      asm_full_reg <= 1'b0;
      else if (complete) asm_full_reg <= 1'b1;

      if (load_out) begin
        out_reg     <= asm_word;
        out_val_reg <= 1'b1;
      end else if (str_ker_rdy) begin
        out_val_reg <= 1'b0;
      end
    end
  end

  // up_rdy is built only from registers so str_ker_rdy never reaches it.
  assign up_rdy      = (state_reg == ST_ACTIVE) && !asm_full_reg;
  assign str_ker     = out_reg;
  assign str_ker_val = out_val_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_kernel_stream_pack.sv
// Directed bench for kernel_stream_pack: a beat-to-word model feeds an expected
// word queue that a negedge compare process checks on every handshake.
module tb_kernel_stream_pack;

  localparam int W  = 64;
  localparam int OW = 256;
  localparam int R  = OW / W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cfg_data = '0;
  logic [4:0]    cfg_addr = '0;
  logic          cfg_valid = 1'b0;
  logic [W-1:0]  up_data = '0;
  logic          up_val = 1'b0;
  logic          up_rdy;
  logic [OW-1:0] str_ker;
  logic          str_ker_val;
  logic          str_ker_rdy = 1'b1;
  logic          busy;

  kernel_stream_pack dut (
    .clk(clk), .rst(rst),
    .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
    .up_data(up_data), .up_val(up_val), .up_rdy(up_rdy),
    .str_ker(str_ker), .str_ker_val(str_ker_val), .str_ker_rdy(str_ker_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            beats_seen = 0;
  int            model_left = 0;
  int            cur_n = 0;
  logic [OW-1:0] cur_word = '0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got_q[$];
  logic          prev_hold = 1'b0;
  logic [OW-1:0] prev_data = '0;
  logic          rand_done = 1'b0;

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Model: beats fill slots 0..R-1 in order; a word closes when full or
  // when the armed count runs out (remaining slots stay zero).
  always @(negedge clk) begin
    if (!rst) begin
      if (up_val && up_rdy) begin
        beats_seen++;
        chk("beat_within_count", 256'(model_left > 0), 256'd1);
        if (model_left > 0) begin
          cur_word[cur_n*W +: W] = up_data;
          cur_n++;
          model_left--;
          if (cur_n == R || model_left == 0) begin
            exp_q.push_back(cur_word);
            cur_word = '0;
            cur_n = 0;
          end
        end
      end
      if (prev_hold) begin
        chk("hold_val", 256'(str_ker_val), 256'd1);
        chk("hold_data", str_ker, prev_data);
      end
      if (!busy) begin
        chk("idle_val", 256'(str_ker_val), 256'd0);
        chk("idle_up_rdy", 256'(up_rdy), 256'd0);
      end
      if (str_ker_val && str_ker_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_word", str_ker, 256'd0);
        else chk("word", str_ker, exp_q.pop_front());
        got_q.push_back(str_ker);
      end
      prev_hold = str_ker_val && !str_ker_rdy;
      prev_data = str_ker;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input logic [31:0] d, input logic [4:0] a);
    cfg_data = d; cfg_addr = a; cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0; cfg_data = '0; cfg_addr = '0;
  endtask

  task automatic start(input int n);
    model_left = n;
    cfg_write(32'(n), 5'd2);
  endtask

  task automatic send(input int n, input logic [W-1:0] base, input bit rand_gap);
    for (int i = 0; i < n; i++) begin
      if (rand_gap) begin
        up_val = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      up_val = 1'b1;
      up_data = base + W'(i);
      begin
        int t = 0;
        @(negedge clk);
        while (!up_rdy && t < 300) begin
          @(negedge clk);
          t++;
        end
        if (t >= 300) chk("beat_timeout", 256'd1, 256'd0);
      end
      step();
    end
    up_val = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", 256'(busy), 256'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    cur_word = '0;
    cur_n = 0;
    model_left = 0;
    prev_hold = 1'b0;
  endtask

  int base_cnt;

  initial begin
    #1;
    chk("reset_up_rdy", 256'(up_rdy), 256'd0);
    chk("reset_str_ker", str_ker, 256'd0);
    chk("reset_val", 256'(str_ker_val), 256'd0);
    chk("reset_busy", 256'(busy), 256'd0);
    step(); step();
    rst = 1'b0;
    step();

    // N=8 back-to-back, rdy held high
    str_ker_rdy = 1'b1;
    start(8);
    send(8, 64'd1, 1'b0);
    @(negedge clk);
    chk("t1_latency_val", 256'(str_ker_val), 256'd1);
    chk("t1_word2_lit", str_ker, {64'd8, 64'd7, 64'd6, 64'd5});
    @(negedge clk);
    chk("t1_busy_after_consume", 256'(busy), 256'd1);
    @(negedge clk);
    chk("t1_busy_drop", 256'(busy), 256'd0);
    chk("t1_word1_lit", got_q[0], {64'd4, 64'd3, 64'd2, 64'd1});
    chk("t1_word_count", 256'(got_q.size()), 256'd2);
    step();

    // N=6 -> padded second word
    base_cnt = got_q.size();
    start(6);
    send(6, 64'd1, 1'b0);
    wait_idle();
    repeat (3) step();
    chk("t2_up_rdy_idle", 256'(up_rdy), 256'd0);
    chk("t2_word_count", 256'(got_q.size() - base_cnt), 256'd2);
    chk("t2_padded_lit", got_q[got_q.size()-1], {64'd0, 64'd0, 64'd6, 64'd5});

    // N=12 with backpressure
    base_cnt = got_q.size();
    beats_seen = 0;
    str_ker_rdy = 1'b0;
    start(12);
    send(8, 64'h100, 1'b0);
    up_val = 1'b1;
    up_data = 64'h108;
    repeat (12) step();
    chk("t3_up_rdy_stall", 256'(up_rdy), 256'd0);
    chk("t3_beats_accepted", 256'(beats_seen), 256'd8);
    chk("t3_held_word", str_ker, {64'h103, 64'h102, 64'h101, 64'h100});
    str_ker_rdy = 1'b1;
    send(4, 64'h108, 1'b0);
    wait_idle();
    chk("t3_word_count", 256'(got_q.size() - base_cnt), 256'd3);
    chk("t3_last_lit", got_q[got_q.size()-1], {64'h10b, 64'h10a, 64'h109, 64'h108});

    // Config while busy, zero count, wrong address
    base_cnt = got_q.size();
    start(8);
    send(2, 64'h200, 1'b0);
    cfg_write(32'd3, 5'd2);
    send(6, 64'h202, 1'b0);
    wait_idle();
    chk("t4_word_count", 256'(got_q.size() - base_cnt), 256'd2);
    cfg_write(32'd0, 5'd2);
    @(negedge clk);
    chk("t4_zero_count_idle", 256'(busy), 256'd0);
    step();
    cfg_write(32'd5, 5'd7);
    @(negedge clk);
    chk("t4_bad_addr_idle", 256'(busy), 256'd0);
    step();

    // Reset mid-transfer
    start(8);
    send(5, 64'h300, 1'b0);
    #1 rst = 1'b1;
    clear_model();
    #1;
    chk("t5_rst_up_rdy", 256'(up_rdy), 256'd0);
    chk("t5_rst_str_ker", str_ker, 256'd0);
    chk("t5_rst_val", 256'(str_ker_val), 256'd0);
    chk("t5_rst_busy", 256'(busy), 256'd0);
    step();
    rst = 1'b0;
    step();
    base_cnt = got_q.size();
    start(4);
    send(4, 64'd21, 1'b0);
    wait_idle();
    chk("t5_word_count", 256'(got_q.size() - base_cnt), 256'd1);
    chk("t5_word_lit", got_q[got_q.size()-1], {64'd24, 64'd23, 64'd22, 64'd21});

    // Random valid/ready toggling, N=40
    base_cnt = got_q.size();
    start(40);
    fork
      begin
        send(40, 64'h4000, 1'b1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          str_ker_rdy = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    str_ker_rdy = 1'b1;
    wait_idle();
    chk("t6_word_count", 256'(got_q.size() - base_cnt), 256'd10);
    chk("t6_queue_empty", 256'(exp_q.size()), 256'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
